mac_array_ctrl: RTL and testbench
=================================

# mac_array_ctrl

Sequencer for the row×col array of mac tiles. It accepts a start command with a dataflow mode and vector count, then drives the array's shared control lines: per-row `inst_w`, `weight_stationary`, `pass_psum`, `recall_psum` and an array clear. It also drives the read port of the activation/weight SRAM. It sits between the core's top-level command interface and the mac array plus its L0/IFIFO front end.

## Interface
Parameters:
- `row`, 8: array rows (PE rows fed from the west).
- `col`, 8: array columns.
- `cnt_w`, 11: width of the vector-count input.
- `addr_w`, 11: SRAM read-address width; must satisfy 2^addr_w ≥ row + max `num_vec`.

Ports (clk and reset first). Clock is `clk`. Reset is `reset`, asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: async active-high reset.
- `start` in 1: command strobe; sampled only in IDLE.
- `mode_ws` in 1: 1 = weight-stationary, 0 = output-stationary; sampled with `start`.
- `num_vec` in cnt_w: number of activation vectors; sampled with `start`.
- `busy` out 1: high from CLR through DONE inclusive.
- `done` out 1: one-cycle pulse in DONE.
- `weight_stationary` out 1: mode line to all tiles; held constant during an operation.
- `inst_w` out 2: instruction into column 0 of every row.
- `pass_psum` out 1: OS psum shift-down enable.
- `recall_psum` out 1: OS psum recall strobe.
- `array_reset` out 1: synchronous clear pulse to the mac array.
- `rd_en` out 1: SRAM read enable.
- `rd_addr` out addr_w: SRAM read address.
- `psum_valid` out 1: bottom-row `out_s` carries a final OS psum this cycle.

## Operation
- All outputs are registered Moore outputs, decoded from the state register and counters.
- States: IDLE, CLR, LOAD, LWAIT, EXEC, DRAIN, RECALL, PASS, DONE.
- IDLE: all outputs 0 except `weight_stationary`, which holds its last value.
  - `start`=1 with `num_vec`≠0 → CLR; latch `mode_ws` into `weight_stationary` and latch `num_vec`.
  - `start`=1 with `num_vec`=0 → DONE directly; no array activity, `array_reset` not pulsed.
- CLR (1 cycle): `array_reset`=1, which re-arms each tile's kernel-load latch and clears its psums. Next state is LOAD if WS, EXEC if OS.
- WS path:
  - LOAD (row cycles): `inst_w`=01, `rd_en`=1, `rd_addr` 0..row-1.
  - LWAIT (col cycles): `inst_w`=00 while the kernel propagates east.
  - EXEC (num_vec cycles): `inst_w`=10, `rd_en`=1, `rd_addr` row..row+num_vec-1.
  - DRAIN (row+col-1 cycles): `inst_w`=00. Then DONE.
- OS path:
  - EXEC (num_vec cycles): `inst_w`=01, `rd_en`=1, `rd_addr` 0..num_vec-1.
  - DRAIN (row+col-2 cycles): `inst_w`=00.
  - RECALL (1 cycle): `recall_psum`=1.
  - PASS (row cycles): `pass_psum`=1 and `psum_valid`=1 each cycle. Then DONE.
- DONE (1 cycle): `done`=1, `busy`=1. Then IDLE.
- `pass_psum` and `recall_psum` are never high together, and are never high in WS mode.
- `inst_w` is always 00 whenever `pass_psum` or `recall_psum` is high.
- `start` asserted outside IDLE is ignored, with no queuing. `start` in the DONE cycle is also ignored.
- Counters:
  - One phase counter, reset to 0 on every state entry; a state exits when the counter reaches its length−1.
  - One address counter, wrap-free within one operation.

## Timing
- Reset (async assert): state=IDLE, every output 0 including `weight_stationary`, all counters 0.
- Reset mid-operation: abort immediately to IDLE. No `done` pulse is issued and `array_reset` is not pulsed. The array must be reset by the system reset.
- Latency: CLR is the cycle after the edge that samples `start`.
- Busy cycles:
  - WS: 1+row+col+num_vec+(row+col-1)+1. With 8/8/16: 49.
  - OS: 1+num_vec+(row+col-2)+1+row+1. With 8/8/16: 41.
- `rd_addr` holds its last value when `rd_en`=0. It is 0 in IDLE.
- Back-to-back operations: the earliest next CLR is 2 cycles after DONE (IDLE samples `start`, then CLR).

## Test plan
- Reset then idle: all outputs 0. `start`=1, `mode_ws`=1, `num_vec`=16 → `array_reset` high 1 cycle; `inst_w`=01 for 8 cycles with `rd_addr` 0..7; 00 for 8 cycles; 10 for 16 cycles with `rd_addr` 8..23; 00 for 15 cycles; `done` pulses. `busy` high for exactly 49 cycles.
- OS, `num_vec`=16 → `inst_w`=01 for 16 cycles (`rd_addr` 0..15); 14 idle cycles; `recall_psum` for 1 cycle; `pass_psum`=`psum_valid`=1 for 8 cycles; `done`. `busy` high for 41 cycles. `weight_stationary`=0 throughout.
- `start` with `num_vec`=0 → `done` pulses on the next cycle; `array_reset`, `rd_en` and `inst_w` stay 0. `busy` high for 1 cycle.
- Re-assert `start` (opposite mode) during EXEC and during DONE → ignored. The operation completes unchanged and `weight_stationary` never toggles mid-operation.
- Assert `reset` during WS EXEC (cycle 5 of 16) → all outputs 0 asynchronously and no `done` pulse. A fresh OS start then completes in 41 cycles.
- Parameter sweep row=4, col=2, WS, `num_vec`=1 → LOAD 4 cycles, LWAIT 2, EXEC 1, DRAIN 5; `busy` for 14 cycles.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequencer for a row x col mac array.
// Takes a start command with a dataflow mode and a vector count. Drives the shared array
// control lines (inst_w, weight_stationary, pass_psum, recall_psum, array_reset), the
// activation/weight SRAM read port (rd_en, rd_addr) and psum_valid.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start, mode_ws,        command strobe, mode (1 = WS, 0 = OS) and vector count;
//   num_vec                all three are sampled only in IDLE
//   busy, done             busy from CLR through DONE; done is a one-cycle pulse
//   weight_stationary      mode line, latched at start and held between operations
//   inst_w                 column-0 instruction (01 load/compute-OS, 10 execute-WS)
//   pass_psum, recall_psum OS psum shift-down enable and recall strobe
//   array_reset            one-cycle clear pulse to the array
//   rd_en, rd_addr         SRAM read port; rd_addr holds while rd_en is low
//   psum_valid             bottom-row out_s carries a final OS psum
//
// Every output is a register loaded from the next-state decode. Assumes row + col >= 3.
module mac_array_ctrl #(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter int unsigned cnt_w  = 11,
    parameter int unsigned addr_w = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_ws,
    input  logic [cnt_w-1:0]  num_vec,
    output logic              busy,
    output logic              done,
    output logic              weight_stationary,
    output logic [1:0]        inst_w,
    output logic              pass_psum,
    output logic              recall_psum,
    output logic              array_reset,
    output logic              rd_en,
    output logic [addr_w-1:0] rd_addr,
    output logic              psum_valid
);

    // The phase counter must hold both num_vec-1 and the longest fixed phase (row+col-2).
    localparam int unsigned RcW = $clog2(row + col + 1);
    localparam int unsigned PhW = (cnt_w > RcW) ? cnt_w : RcW;

    localparam logic [PhW-1:0] LoadLast    = PhW'(row - 1);
    localparam logic [PhW-1:0] LwaitLast   = PhW'(col - 1);
    localparam logic [PhW-1:0] DrainWsLast = PhW'(row + col - 2);
    localparam logic [PhW-1:0] DrainOsLast = PhW'(row + col - 3);
    localparam logic [PhW-1:0] PassLast    = PhW'(row - 1);

    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StLoad,
        StLwait,
        StExec,
        StDrain,
        StRecall,
        StPass,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [PhW-1:0]    cnt_q, cnt_d;
    logic [addr_w-1:0] addr_q, addr_d;
    logic [cnt_w-1:0]  nv_q, nv_d;
    logic              ws_q, ws_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        inst_q, inst_d;
    logic              pass_q, pass_d;
    logic              recall_q, recall_d;
    logic              clr_q, clr_d;
    logic              rd_en_q, rd_en_d;

    logic [PhW-1:0]    exec_last;

    assign exec_last = PhW'(nv_q) - PhW'(1);

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        nv_d    = nv_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_vec != '0) begin
                        state_d = StClr;
                        ws_d    = mode_ws;
                        nv_d    = num_vec;
                    end else begin
                        // Empty command: acknowledge without touching the array.
                        state_d = StDone;
                    end
                end
            end
            StClr:    state_d = ws_q ? StLoad : StExec;
            StLoad:   if (cnt_q == LoadLast)  state_d = StLwait;
            StLwait:  if (cnt_q == LwaitLast) state_d = StExec;
            StExec:   if (cnt_q == exec_last) state_d = StDrain;
            StDrain: begin
                if (ws_q) begin
                    if (cnt_q == DrainWsLast) state_d = StDone;
                end else begin
                    if (cnt_q == DrainOsLast) state_d = StRecall;
                end
            end
            StRecall: state_d = StPass;
            StPass:   if (cnt_q == PassLast) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Phase counter restarts on every state entry.
        if (state_d == StIdle || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PhW'(1);
        end

        // Address: 0 at LOAD entry or OS EXEC entry. WS EXEC continues from row-1, so its
        // first address is row. Held in every non-reading state.
        if (state_d == StIdle) begin
            addr_d = '0;
        end else if (state_d == StLoad && state_q != StLoad) begin
            addr_d = '0;
        end else if (state_d == StExec && state_q == StClr) begin
            addr_d = '0;
        end else if (state_d == StLoad || state_d == StExec) begin
            addr_d = addr_q + addr_w'(1);
        end else begin
            addr_d = addr_q;
        end

        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        clr_d    = (state_d == StClr);
        rd_en_d  = (state_d == StLoad) || (state_d == StExec);
        recall_d = (state_d == StRecall);
        pass_d   = (state_d == StPass);

        inst_d = 2'b00;
        if (state_d == StLoad) begin
            inst_d = 2'b01;
        end else if (state_d == StExec) begin
            inst_d = ws_d ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            nv_q     <= '0;
            ws_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            inst_q   <= 2'b00;
            pass_q   <= 1'b0;
            recall_q <= 1'b0;
            clr_q    <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            nv_q     <= nv_d;
            ws_q     <= ws_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            inst_q   <= inst_d;
            pass_q   <= pass_d;
            recall_q <= recall_d;
            clr_q    <= clr_d;
            rd_en_q  <= rd_en_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign weight_stationary = ws_q;
    assign inst_w            = inst_q;
    assign pass_psum         = pass_q;
    assign recall_psum       = recall_q;
    assign array_reset       = clr_q;
    assign rd_en             = rd_en_q;
    assign rd_addr           = addr_q;
    assign psum_valid        = pass_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
module tb_mac_array_ctrl;

    localparam int unsigned CntW  = 11;
    localparam int unsigned AddrW = 11;

    logic clk = 1'b0;
    logic reset;

    // Main instance: 8x8.
    logic             start, mode_ws;
    logic [CntW-1:0]  num_vec;
    logic             busy, done, weight_stationary, pass_psum, recall_psum;
    logic             array_reset, rd_en, psum_valid;
    logic [1:0]       inst_w;
    logic [AddrW-1:0] rd_addr;

    // Sweep instance: 4x2.
    logic             b_start, b_mode_ws;
    logic [CntW-1:0]  b_num_vec;
    logic             b_busy, b_done, b_weight_stationary, b_pass_psum, b_recall_psum;
    logic             b_array_reset, b_rd_en, b_psum_valid;
    logic [1:0]       b_inst_w;
    logic [AddrW-1:0] b_rd_addr;

    logic [20:0] obs1, obs2;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mac_array_ctrl #(.row(8), .col(8), .cnt_w(CntW), .addr_w(AddrW)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mode_ws           (mode_ws),
        .num_vec           (num_vec),
        .busy              (busy),
        .done              (done),
        .weight_stationary (weight_stationary),
        .inst_w            (inst_w),
        .pass_psum         (pass_psum),
        .recall_psum       (recall_psum),
        .array_reset       (array_reset),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .psum_valid        (psum_valid)
    );

    mac_array_ctrl #(.row(4), .col(2), .cnt_w(CntW), .addr_w(AddrW)) u_dut_small (
        .clk               (clk),
        .reset             (reset),
        .start             (b_start),
        .mode_ws           (b_mode_ws),
        .num_vec           (b_num_vec),
        .busy              (b_busy),
        .done              (b_done),
        .weight_stationary (b_weight_stationary),
        .inst_w            (b_inst_w),
        .pass_psum         (b_pass_psum),
        .recall_psum       (b_recall_psum),
        .array_reset       (b_array_reset),
        .rd_en             (b_rd_en),
        .rd_addr           (b_rd_addr),
        .psum_valid        (b_psum_valid)
    );

    // Packed view: {busy, done, ws, inst_w[1:0], pass, recall, array_reset, rd_en, psum_valid,
    // rd_addr[10:0]}
    assign obs1 = {busy, done, weight_stationary, inst_w, pass_psum, recall_psum,
                   array_reset, rd_en, psum_valid, rd_addr};
    assign obs2 = {b_busy, b_done, b_weight_stationary, b_inst_w, b_pass_psum, b_recall_psum,
                   b_array_reset, b_rd_en, b_psum_valid, b_rd_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int cyc, input logic [20:0] got,
                         input logic [20:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s[%0d]: observed %h expected %h", tag, cyc, got, exp);
    endtask

    // Checks one phase of len cycles on instance sel, then advances a cycle per check.
    task automatic ph(input bit sel, input string tag, input int len, input bit ws,
                      input logic [1:0] iw, input bit rde, input int a0, input bit ainc,
                      input bit ar, input bit rc, input bit ps, input bit bz, input bit dn);
        logic [AddrW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = AddrW'(ainc ? a0 + i : a0);
            check(tag, i, sel ? obs2 : obs1, {bz, dn, ws, iw, ps, rc, ar, rde, ps, a});
            tick();
        end
    endtask

    task automatic idle(input bit sel, input string tag, input int len, input bit ws);
        ph(sel, tag, len, ws, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input bit m, input int nv);
        start   = 1'b1;
        mode_ws = m;
        num_vec = CntW'(nv);
        tick();
        start   = 1'b0;
    endtask

    task automatic os16(input string tag);
        go(1'b0, 16);
        ph(0, {tag, "_clr"},    1,  0, 2'b00, 0, 0,  0, 1, 0, 0, 1, 0);
        ph(0, {tag, "_exec"},   16, 0, 2'b01, 1, 0,  1, 0, 0, 0, 1, 0);
        ph(0, {tag, "_drain"},  14, 0, 2'b00, 0, 15, 0, 0, 0, 0, 1, 0);
        ph(0, {tag, "_recall"}, 1,  0, 2'b00, 0, 15, 0, 0, 1, 0, 1, 0);
        ph(0, {tag, "_pass"},   8,  0, 2'b00, 0, 15, 0, 0, 0, 1, 1, 0);
        ph(0, {tag, "_done"},   1,  0, 2'b00, 0, 15, 0, 0, 0, 0, 1, 1);
        idle(0, {tag, "_idle"}, 2, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mode_ws   = 1'b0;
        num_vec   = '0;
        b_start   = 1'b0;
        b_mode_ws = 1'b0;
        b_num_vec = '0;

        #3;
        check("reset_main", 0, obs1, 21'd0);
        check("reset_small", 0, obs2, 21'd0);
        tick();
        tick();
        reset = 1'b0;
        idle(0, "idle_after_reset", 3, 0);

        // WS, 16 vectors: 1 + 8 + 8 + 16 + 15 + 1 = 49 busy cycles.
        go(1'b1, 16);
        ph(0, "ws_clr",   1,  1, 2'b00, 0, 0,  0, 1, 0, 0, 1, 0);
        ph(0, "ws_load",  8,  1, 2'b01, 1, 0,  1, 0, 0, 0, 1, 0);
        ph(0, "ws_lwait", 8,  1, 2'b00, 0, 7,  0, 0, 0, 0, 1, 0);
        ph(0, "ws_exec",  16, 1, 2'b10, 1, 8,  1, 0, 0, 0, 1, 0);
        ph(0, "ws_drain", 15, 1, 2'b00, 0, 23, 0, 0, 0, 0, 1, 0);
        ph(0, "ws_done",  1,  1, 2'b00, 0, 23, 0, 0, 0, 0, 1, 1);
        idle(0, "ws_idle", 2, 1);

        // OS, 16 vectors: 41 busy cycles.
        os16("os");

        // Empty command: DONE on the next cycle only.
        go(1'b0, 0);
        ph(0, "zero_done", 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0, "zero_idle", 2, 0);

        // WS, 4 vectors, with start (OS mode) re-asserted in EXEC and in DONE.
        go(1'b1, 4);
        ph(0, "ign_clr",   1, 1, 2'b00, 0, 0, 0, 1, 0, 0, 1, 0);
        ph(0, "ign_load",  8, 1, 2'b01, 1, 0, 1, 0, 0, 0, 1, 0);
        ph(0, "ign_lwait", 8, 1, 2'b00, 0, 7, 0, 0, 0, 0, 1, 0);
        ph(0, "ign_exec0", 2, 1, 2'b10, 1, 8, 1, 0, 0, 0, 1, 0);
        start   = 1'b1;
        mode_ws = 1'b0;
        num_vec = CntW'(2);
        ph(0, "ign_exec1",  2,  1, 2'b10, 1, 10, 1, 0, 0, 0, 1, 0);
        start = 1'b0;
        ph(0, "ign_drain", 15, 1, 2'b00, 0, 11, 0, 0, 0, 0, 1, 0);
        start = 1'b1;
        ph(0, "ign_done",  1,  1, 2'b00, 0, 11, 0, 0, 0, 0, 1, 1);
        start = 1'b0;
        idle(0, "ign_idle", 3, 1);

        // Reset during the 5th WS EXEC cycle.
        go(1'b1, 16);
        ph(0, "rst_clr",   1, 1, 2'b00, 0, 0, 0, 1, 0, 0, 1, 0);
        ph(0, "rst_load",  8, 1, 2'b01, 1, 0, 1, 0, 0, 0, 1, 0);
        ph(0, "rst_lwait", 8, 1, 2'b00, 0, 7, 0, 0, 0, 0, 1, 0);
        ph(0, "rst_exec",  4, 1, 2'b10, 1, 8, 1, 0, 0, 0, 1, 0);
        check("rst_exec5", 0, obs1, {1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                     11'd12});
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", 0, obs1, 21'd0);
        tick();
        reset = 1'b0;
        idle(0, "rst_idle", 3, 0);
        os16("os2");

        // Sweep instance 4x2, WS, one vector: 1 + 4 + 2 + 1 + 5 + 1 = 14 busy cycles.
        b_start   = 1'b1;
        b_mode_ws = 1'b1;
        b_num_vec = CntW'(1);
        tick();
        b_start = 1'b0;
        ph(1, "sw_clr",   1, 1, 2'b00, 0, 0, 0, 1, 0, 0, 1, 0);
        ph(1, "sw_load",  4, 1, 2'b01, 1, 0, 1, 0, 0, 0, 1, 0);
        ph(1, "sw_lwait", 2, 1, 2'b00, 0, 3, 0, 0, 0, 0, 1, 0);
        ph(1, "sw_exec",  1, 1, 2'b10, 1, 4, 0, 0, 0, 0, 1, 0);
        ph(1, "sw_drain", 5, 1, 2'b00, 0, 4, 0, 0, 0, 0, 1, 0);
        ph(1, "sw_done",  1, 1, 2'b00, 0, 4, 0, 0, 0, 0, 1, 1);
        idle(1, "sw_idle", 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
